// File: rtl/serial_tx_pkg.sv
// Shared types and sizing helpers for the serial transmit scheduler.
package serial_tx_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Index width for n items, never below one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester handshake plus serial lane signals for serial_tx_scheduler.
interface serial_tx_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  import serial_tx_pkg::*;

  localparam int unsigned GRANT_W = grant_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          dout;
  logic                          dout_valid;
  logic                          dout_first;
  logic                          dout_last;
  logic [GRANT_W-1:0]            grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, dout, dout_valid, dout_first, dout_last, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, dout, dout_valid, dout_first, dout_last, grant_id, busy
  );

endinterface

// File: rtl/serial_tx_scheduler_rr_pick.sv
// Combinational round-robin pick: first set request above ptr, wrapping around.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GRANT_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [GRANT_W-1:0] grant_idx_c,
  output logic               any_valid_c
);

  logic [GRANT_W-1:0] idx;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_valid_c = 1'b0;
    idx         = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = GRANT_W'((32'(ptr) + off) % NUM_REQ);
      if (!any_valid_c && req[idx]) begin
        any_valid_c  = 1'b1;
        grant_idx_c  = idx;
        grant_c[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin share of one LSB-first serial lane between NUM_REQ parallel requesters.
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_tx_scheduler_if.slave  bus
);

  localparam int unsigned GRANT_W = grant_w(NUM_REQ);
  localparam int unsigned CNT_W   = grant_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GRANT_W-1:0] PTR_INIT = GRANT_W'(NUM_REQ - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [GRANT_W-1:0]      ptr_q, ptr_d;
  logic [GRANT_W-1:0]      gid_q, gid_d;

  logic [NUM_REQ-1:0]      pick_grant_c;
  logic [GRANT_W-1:0]      pick_idx_c;
  logic                    pick_any_c;
  logic                    last_bit_c;
  logic                    accept_c;
  logic [DATA_WIDTH-1:0]   word_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .req         (bus.req_valid),
    .ptr         (ptr_q),
    .grant_c     (pick_grant_c),
    .grant_idx_c (pick_idx_c),
    .any_valid_c (pick_any_c)
  );

  // Accept window is idle or the final bit of the current frame; reset blocks it.
  always_comb begin
    last_bit_c = (state_q == SHIFT) && (cnt_q == LAST_BIT);
    accept_c   = !reset && ((state_q == IDLE) || last_bit_c) && pick_any_c;
    word_c     = bus.req_data[32'(pick_idx_c) * DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.req_ready  = accept_c ? pick_grant_c : '0;
  assign bus.dout_valid = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.dout       = (state_q == SHIFT) & shift_q[0];
  assign bus.dout_first = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.dout_last  = last_bit_c;
  assign bus.grant_id   = gid_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    if (accept_c) begin
      state_d = SHIFT;
      shift_d = word_c;
      cnt_d   = '0;
      ptr_d   = pick_idx_c;
      gid_d   = pick_idx_c;
    end else if (state_q == SHIFT) begin
      if (last_bit_c) begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= PTR_INIT;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Scoreboard bench for serial_tx_scheduler: a round-robin model queues expected serial bits on each accept.
module tb_serial_tx_scheduler;

  typedef struct packed {
    logic       v;
    logic       b;
    logic       f;
    logic       l;
    logic [1:0] g;
  } exp_t;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } cap_t;

  logic clk;
  logic reset;

  serial_tx_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus ();

  serial_tx_scheduler #(.NUM_REQ(4), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  exp_t        sbq[$];
  cap_t        cap[$];
  int          glog[$];
  int          rdy_cnt[4];
  int          mptr;
  bit          mon_en;
  int          run_len;
  int          max_run;
  logic [3:0]  valid;
  logic [3:0]  cont;
  logic [15:0] word[4];
  logic [3:0]  prev_v;
  logic [3:0]  prev_acc;
  logic [15:0] prev_d[4];

  task automatic drive();
    bus.req_valid = valid;
    for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = word[i];
  endtask

  // One clock: check outputs against the scoreboard, check ready against the model, then update requesters.
  task automatic tick();
    exp_t       e;
    logic [3:0] er;
    logic [3:0] rv;
    int         acc;
    @(negedge clk);
    rv = bus.req_valid;
    if (mon_en) begin
      e = '0;
      if (sbq.size() > 0) e = sbq.pop_front();
      checks++;
      if ({bus.dout_valid, bus.busy, bus.dout, bus.dout_first, bus.dout_last} !== {e.v, e.v, e.b, e.f, e.l}) begin
        errors++;
        $display("FAIL serial_out t=%0t got valid/busy/dout/first/last=%b expected %b", $time,
                 {bus.dout_valid, bus.busy, bus.dout, bus.dout_first, bus.dout_last}, {e.v, e.v, e.b, e.f, e.l});
      end
      if (e.v) begin
        checks++;
        if (bus.grant_id !== e.g) begin
          errors++;
          $display("FAIL grant_id t=%0t got %0d expected %0d", $time, bus.grant_id, e.g);
        end
      end
    end
    er  = '0;
    acc = -1;
    if (!reset && sbq.size() == 0) begin
      for (int off = 1; off <= 4; off++) begin
        int idx;
        idx = (mptr + off) % 4;
        if (acc < 0 && rv[idx]) begin
          acc     = idx;
          er[idx] = 1'b1;
        end
      end
    end
    checks++;
    if (bus.req_ready !== er) begin
      errors++;
      $display("FAIL req_ready t=%0t got %b expected %b", $time, bus.req_ready, er);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.req_ready[i] === 1'b1) rdy_cnt[i]++;
      if (prev_v[i] && !prev_acc[i] && rv[i]) begin
        checks++;
        if (bus.req_data[i*16 +: 16] !== prev_d[i]) begin
          errors++;
          $display("FAIL data_stable req=%0d got %h expected %h", i, bus.req_data[i*16 +: 16], prev_d[i]);
        end
      end
      prev_d[i] = bus.req_data[i*16 +: 16];
    end
    prev_v   = rv;
    prev_acc = er;
    if (bus.dout_valid === 1'b1) begin
      cap.push_back('{b: bus.dout, f: bus.dout_first, l: bus.dout_last});
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (reset) begin
      sbq.delete();
      mptr   = 3;
      mon_en = 1'b1;
    end else if (acc >= 0) begin
      for (int k = 0; k < 16; k++)
        sbq.push_back('{v: 1'b1, b: word[acc][k], f: (k == 0), l: (k == 15), g: 2'(acc)});
      mptr = acc;
      glog.push_back(acc);
    end
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      if (cont[acc]) word[acc] = word[acc] + 16'h1111;
      else           valid[acc] = 1'b0;
      drive();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    valid = '0;
    drive();
    do_reset(2);
    checks++;
    if ({bus.dout, bus.dout_valid, bus.dout_first, bus.dout_last, bus.busy, bus.grant_id, bus.req_ready} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got dout/v/f/l/busy/gid/ready=%b expected all zero",
               {bus.dout, bus.dout_valid, bus.dout_first, bus.dout_last, bus.busy, bus.grant_id, bus.req_ready});
    end
    repeat (2) tick();
  endtask

  task automatic test_single();
    bit exp_bits[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    int r1, g0;
    cap.delete();
    r1 = rdy_cnt[1];
    g0 = glog.size();
    word[1] = 16'hA5C3;
    valid   = 4'b0010;
    drive();
    repeat (20) tick();
    checks++;
    if (rdy_cnt[1] - r1 != 1) begin
      errors++;
      $display("FAIL single_ready_pulses got %0d expected 1", rdy_cnt[1] - r1);
    end
    checks++;
    if (glog.size() - g0 != 1 || glog[g0] != 1) begin
      errors++;
      $display("FAIL single_grant got count=%0d first=%0d expected count=1 first=1", glog.size() - g0, glog[g0]);
    end
    checks++;
    if (cap.size() != 16) begin
      errors++;
      $display("FAIL single_frame_len got %0d expected 16", cap.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (cap[k].b !== exp_bits[k] || cap[k].f !== (k == 0) || cap[k].l !== (k == 15)) begin
          errors++;
          $display("FAIL single_bit%0d got d/f/l=%b%b%b expected %b%b%b", k, cap[k].b, cap[k].f, cap[k].l,
                   exp_bits[k], (k == 0), (k == 15));
        end
      end
    end
  endtask

  task automatic test_all_four();
    int g0;
    do_reset(1);
    cap.delete();
    max_run = 0;
    run_len = 0;
    g0 = glog.size();
    word[0] = 16'h1111; word[1] = 16'h2222; word[2] = 16'h3333; word[3] = 16'h4444;
    valid = 4'b1111;
    drive();
    repeat (70) tick();
    checks++;
    if (glog.size() - g0 != 4) begin
      errors++;
      $display("FAIL all4_grant_count got %0d expected 4", glog.size() - g0);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (glog[g0 + k] != k) begin
        errors++;
        $display("FAIL all4_order slot%0d got %0d expected %0d", k, glog[g0 + k], k);
      end
    end
    checks++;
    if (max_run != 64) begin
      errors++;
      $display("FAIL all4_continuous got %0d expected 64", max_run);
    end
  endtask

  task automatic test_round_robin();
    int g0;
    g0 = glog.size();
    cont    = 4'b0101;
    word[0] = 16'h0F0F;
    word[2] = 16'hF0F0;
    valid   = 4'b0101;
    drive();
    repeat (65) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (glog[g0 + k] != ((k % 2) * 2)) begin
        errors++;
        $display("FAIL rr_order slot%0d got %0d expected %0d", k, glog[g0 + k], (k % 2) * 2);
      end
    end
    cont  = '0;
    valid = '0;
    drive();
    repeat (20) tick();
  endtask

  task automatic test_reset_mid_frame();
    int g0;
    g0 = glog.size();
    word[3] = 16'hBEEF;
    valid   = 4'b1000;
    drive();
    tick();
    repeat (7) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.dout, bus.dout_valid, bus.busy, bus.dout_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_frame got dout/v/busy/last=%b expected 0000",
               {bus.dout, bus.dout_valid, bus.busy, bus.dout_last});
    end
    reset   = 1'b0;
    word[0] = 16'h1357;
    word[3] = 16'h2468;
    valid   = 4'b1001;
    drive();
    repeat (36) tick();
    checks++;
    if (glog.size() - g0 != 3 || glog[g0] != 3 || glog[g0 + 1] != 0 || glog[g0 + 2] != 3) begin
      errors++;
      $display("FAIL reset_mid_order got n=%0d %0d,%0d,%0d expected n=3 3,0,3", glog.size() - g0,
               glog[g0], glog[g0 + 1], glog[g0 + 2]);
    end
  endtask

  task automatic test_drop_before_accept();
    int g0, r1;
    g0 = glog.size();
    r1 = rdy_cnt[1];
    word[0] = 16'h1234;
    valid   = 4'b0001;
    drive();
    repeat (4) tick();
    valid[1] = 1'b1;
    word[1]  = 16'hFFFF;
    drive();
    tick();
    valid[1] = 1'b0;
    drive();
    repeat (20) tick();
    checks++;
    if (rdy_cnt[1] != r1 || glog.size() - g0 != 1) begin
      errors++;
      $display("FAIL drop_skip got ready1=%0d grants=%0d expected ready1=0 grants=1", rdy_cnt[1] - r1, glog.size() - g0);
    end
    checks++;
    if ({bus.dout, bus.dout_valid} !== 2'b00) begin
      errors++;
      $display("FAIL drop_idle got dout/v=%b expected 00", {bus.dout, bus.dout_valid});
    end
  endtask

  task automatic test_zero_word();
    int ones, nf, nl;
    cap.delete();
    word[0] = 16'h0000;
    valid   = 4'b0001;
    drive();
    repeat (20) tick();
    ones = 0; nf = 0; nl = 0;
    foreach (cap[k]) begin
      if (cap[k].b !== 1'b0) ones++;
      if (cap[k].f === 1'b1) nf++;
      if (cap[k].l === 1'b1) nl++;
    end
    checks++;
    if (cap.size() != 16 || ones != 0 || nf != 1 || nl != 1 || cap[0].f !== 1'b1 || cap[15].l !== 1'b1) begin
      errors++;
      $display("FAIL zero_word got len=%0d ones=%0d firsts=%0d lasts=%0d expected 16/0/1/1", cap.size(), ones, nf, nl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    valid    = '0;
    cont     = '0;
    for (int i = 0; i < 4; i++) begin
      word[i]    = '0;
      prev_d[i]  = '0;
      rdy_cnt[i] = 0;
    end
    prev_v   = '0;
    prev_acc = '0;
    mptr     = 3;
    mon_en   = 1'b0;
    run_len  = 0;
    max_run  = 0;
    drive();
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_reset_mid_frame();
    test_drop_before_accept();
    test_zero_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_scheduler.md
Name: serial_tx_scheduler

Overview:
Round-robin scheduler that shares one parallel-in, serial-out shift lane between NUM_REQ requesters. Each requester presents a DATA_WIDTH word with a valid/ready handshake. The scheduler accepts one word at a time, serializes it LSB-first onto a single-bit output with framing strobes, and grants the next requester with no idle cycle between frames. It sits between multiple parallel producers and a single serial link.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 16, bits per word and per serial frame (>=2)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester word-valid
req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot (or zero) accept strobe; transfer when req_valid[i] & req_ready[i]
dout  output  1  serial data, LSB of the accepted word first
dout_valid  output  1  dout carries a frame bit
dout_first  output  1  bit 0 of a frame
dout_last  output  1  bit DATA_WIDTH-1 of a frame
grant_id  output  $clog2(NUM_REQ)  index of the requester whose frame is on dout
busy  output  1  frame in progress (equals dout_valid)

Behaviour:
- Reset: state=IDLE; shift register=0; bit counter=0; rr pointer=NUM_REQ-1, so requester 0 has top priority first. All outputs 0 in the cycle after reset is sampled and while reset is held. req_ready=0 while reset=1.
- States: IDLE and SHIFT, encoded as a 1-bit enum.
- Accept window: state==IDLE, or state==SHIFT with bit_cnt==DATA_WIDTH-1.
- Inside the accept window with any req_valid: the winner is the first valid index searched from ptr+1 upward with wrap-around. req_ready[winner]=1 combinationally in that cycle; all other ready bits are 0. No valid requester means req_ready=0.
- On accept at edge N: shift_reg<=word, ptr<=winner, grant_id<=winner, bit_cnt<=0, state<=SHIFT.
- Latency: dout=bit0 with dout_first=1 in cycle N+1. dout=bit15 with dout_last=1 in cycle N+DATA_WIDTH (for DATA_WIDTH=16).
- SHIFT, not last bit: each cycle shift_reg shifts right by 1 with 0 fill and bit_cnt increments.
- SHIFT, last bit with a new accept: load the new word. The next frame starts the following cycle with no bubble.
- SHIFT, last bit with no accept: state<=IDLE, shift_reg<=0.
- dout = shift_reg[0] qualified by state==SHIFT. Whenever dout_valid=0, dout is 0.
- dout_first=(state==SHIFT && bit_cnt==0); dout_last=(state==SHIFT && bit_cnt==DATA_WIDTH-1); busy=dout_valid=(state==SHIFT).
- A frame always runs the full DATA_WIDTH bits; req_valid changes never abort it.
- A requester that drops req_valid before acceptance is skipped; no grant is held for it.
- Protocol rule: a requester keeps req_data stable while valid and not yet accepted. The design does not check this; the bench does.
- Reset mid-frame: the frame is discarded and there is no partial dout_last. The following cycle has dout=0 and dout_valid=0. The pointer returns to NUM_REQ-1.
- Simultaneous reset and accept window: reset wins and req_ready=0.

Decomposition:
- Package serial_tx_pkg: state enum typedef {IDLE, SHIFT}; GRANT_W = $clog2(NUM_REQ) helper function.
- Sub-module rr_pick: combinational round-robin selector with inputs req vector and ptr, outputs one-hot grant, grant index and any_valid.
- Shift register, bit counter and FSM live in serial_tx_scheduler.

Test Plan:
- Reset; req_valid=4'b0010 with word 16'hA5C3 -> req_ready=4'b0010 for exactly one cycle. Then dout over 16 cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, dout_first on cycle 1, dout_last on cycle 16, grant_id=1. Then dout=0 and dout_valid=0.
- All four requesters valid from reset, each held until accepted -> grant order 0,1,2,3; dout_valid high for 64 consecutive cycles; each next ready pulse coincides with the previous dout_last.
- Requesters 0 and 2 continuously valid -> grant_id sequence 0,2,0,2; requester 2 never waits more than one frame.
- Reset asserted during bit 7 of a frame from requester 3 -> next cycle dout=0, dout_valid=0, busy=0, no dout_last. After release, with req 0 and 3 valid, requester 0 is granted first.
- req_valid[1] pulsed for one cycle while busy and not in the last bit -> req_ready[1] never asserted and no frame for requester 1. With no other requests, dout stays 0.
- Word 16'h0000 from requester 0 -> dout_valid=1 for 16 cycles with dout=0, first and last strobes correct, distinguishable from idle only by dout_valid.
